// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: memory-stage access controller.
// Takes the EX/MEM-latched address and store data and runs a one-cycle
// request / one-cycle done handshake with a variable-latency 16-bit data
// memory. The pipeline is stalled while an access is outstanding. Load data
// comes back through a register that feeds the MEM/WB latch. Unaligned,
// illegal and timed-out accesses set a sticky error flag.
//
//  state | meaning
//  ------+----------------------------------------------------------------
//  IDLE  | no access outstanding; an aligned access issues mem_req here
//  WAIT  | request issued; address/data/direction held, waiting mem_done
//  DONE  | access finished; stall released so the instruction advances
//
// Outputs are combinational from state and inputs, gated by rst. This means
// mem_req and stall drop in the same cycle that reset is asserted, even when
// a live access is still presented at the inputs.

module mem_stage_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [15:0] addr,
    input  logic [15:0] wrData,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_done,
    output logic        stall,
    output logic [15:0] readMemData,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    // Last WAIT count before the access is abandoned; TIMEOUT is limited to 2..255.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
    localparam logic [7:0] CNT_MAX  = 8'hFF;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  cnt;
    logic [7:0]  cnt_nxt;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic        wr_q;

    logic        access;
    logic        illegal;
    logic        unaligned;
    logic        issue;
    logic        set_err;
    logic        cap_rd;
    logic        clr_rd;

    // Classify the instruction in the EX/MEM latch; a bubble is never an access.
    always_comb begin
        access    = valid & (memRead ^ memWrite);
        illegal   = valid & memRead & memWrite;
        unaligned = access & addr[0];
    end

    // Next-state logic, memory-side outputs and the stall request.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mem_req   = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = addr;
        mem_wdata = wrData;
        stall     = 1'b0;
        issue     = 1'b0;
        set_err   = 1'b0;
        cap_rd    = 1'b0;
        clr_rd    = 1'b0;

        case (state)
            IDLE: begin
                if (access && !addr[0]) begin
                    issue     = 1'b1;
                    mem_req   = 1'b1;
                    mem_wr    = memWrite;
                    stall     = 1'b1;
                    cnt_nxt   = 8'd0;
                    state_nxt = WAIT;
                end else if (unaligned || illegal) begin
                    // The faulting instruction still proceeds; only the flag records it.
                    set_err = 1'b1;
                end
            end

            WAIT: begin
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                mem_wr    = wr_q;
                stall     = 1'b1;
                if (mem_done) begin
                    cap_rd    = ~wr_q;
                    state_nxt = DONE;
                end else if (cnt == CNT_LAST) begin
                    set_err   = 1'b1;
                    clr_rd    = 1'b1;
                    state_nxt = DONE;
                end else if (cnt != CNT_MAX) begin
                    cnt_nxt = cnt + 8'd1;
                end
            end

            DONE: begin
                // The instruction is still presented here; going straight to
                // IDLE without looking at the inputs prevents a reissue.
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (rst) begin
            mem_req = 1'b0;
            stall   = 1'b0;
        end
    end

    // State register and wait counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Hold the request fields so memory sees them stable through WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= 16'd0;
            wdata_q <= 16'd0;
            wr_q    <= 1'b0;
        end else if (issue) begin
            addr_q  <= addr;
            wdata_q <= wrData;
            wr_q    <= memWrite;
        end
    end

    // Load result register: captured on a read completion, zeroed on timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            readMemData <= 16'd0;
        end else if (cap_rd) begin
            readMemData <= mem_rdata;
        end else if (clr_rd) begin
            readMemData <= 16'd0;
        end
    end

    // Sticky error flag; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (set_err) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl. It uses a table of idle-cycle
// vectors, a handshake task driving loads and stores against a behavioural
// memory, and a queue of expected load results. Hand-written sequences cover
// the timeout case, reset in the middle of an access, and the error cases.
module tb_mem_stage_ctrl;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic        memRead;
    logic        memWrite;
    logic [15:0] addr;
    logic [15:0] wrData;
    logic        mem_req;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_done;
    logic        stall;
    logic [15:0] readMemData;
    logic        err;

    int checks   = 0;
    int failures = 0;
    int req_cnt  = 0;

    logic [15:0] sb[$];
    logic [15:0] rmd_model;

    typedef struct {
        logic        v;
        logic        rd;
        logic        wr;
        logic [15:0] a;
        logic [15:0] d;
        logic        e_req;
        logic        e_stall;
    } vec_t;

    vec_t vecs[5];

    mem_stage_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .valid       (valid),
        .memRead     (memRead),
        .memWrite    (memWrite),
        .addr        (addr),
        .wrData      (wrData),
        .mem_req     (mem_req),
        .mem_wr      (mem_wr),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_done    (mem_done),
        .stall       (stall),
        .readMemData (readMemData),
        .err         (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (mem_req === 1'b1) req_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic drive_idle();
        valid    = 1'b0;
        memRead  = 1'b0;
        memWrite = 1'b0;
        mem_done = 1'b0;
    endtask

    // n = cycles from mem_req to mem_done; n = 0 means memory never answers.
    task automatic do_access(input logic wr, input logic [15:0] a, input logic [15:0] d,
                             input int n, input logic [15:0] rdata, input logic exp_err,
                             input string tag);
        int          stalls;
        int          exp_stalls;
        logic        done_seen;
        logic [15:0] exp;
        logic [15:0] got;
        step();
        valid    = 1'b1;
        memRead  = ~wr;
        memWrite = wr;
        addr     = a;
        wrData   = d;
        mem_done = 1'b0;
        if (n == 0)  exp = 16'h0000;
        else if (wr) exp = rmd_model;
        else         exp = rdata;
        rmd_model = exp;
        sb.push_back(exp);
        sample();
        chk({tag, " issue_req"},   {15'd0, mem_req}, 16'd1);
        chk({tag, " issue_wr"},    {15'd0, mem_wr},  {15'd0, wr});
        chk({tag, " issue_addr"},  mem_addr,  a);
        chk({tag, " issue_wdata"}, mem_wdata, d);
        chk({tag, " issue_stall"}, {15'd0, stall}, 16'd1);
        stalls    = 1;
        done_seen = 1'b0;
        for (int k = 1; k <= 60 && !done_seen; k++) begin
            step();
            mem_done  = (n != 0 && k == n);
            mem_rdata = (n != 0 && k == n) ? rdata : 16'hDEAD;
            sample();
            if (stall) begin
                stalls++;
                if (k == 1 || k == n) begin
                    chk({tag, " wait_req"},   {15'd0, mem_req}, 16'd0);
                    chk({tag, " wait_addr"},  mem_addr,  a);
                    chk({tag, " wait_wdata"}, mem_wdata, d);
                    chk({tag, " wait_wr"},    {15'd0, mem_wr}, {15'd0, wr});
                end
            end else begin
                done_seen = 1'b1;
            end
        end
        if (!done_seen) begin
            checks++;
            failures++;
            $display("FAIL %s done_bound actual=stalled expected=released", tag);
        end
        exp_stalls = (n == 0) ? TIMEOUT + 1 : n + 1;
        chk({tag, " stall_cycles"}, 16'(stalls), 16'(exp_stalls));
        chk({tag, " done_req"}, {15'd0, mem_req}, 16'd0);
        got = sb.pop_front();
        chk({tag, " readMemData"}, readMemData, got);
        chk({tag, " err"}, {15'd0, err}, {15'd0, exp_err});
        mem_done = 1'b0;
    endtask

    initial begin
        int req_before;

        rst       = 1'b1;
        drive_idle();
        addr      = 16'h0;
        wrData    = 16'h0;
        mem_rdata = 16'h0;
        rmd_model = 16'h0;

        vecs[0] = '{1'b0, 1'b0, 1'b0, 16'h0010, 16'h1111, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 16'h0020, 16'h2222, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 16'h0030, 16'h3333, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 16'h0041, 16'h4444, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 16'h0051, 16'h5555, 1'b0, 1'b0};

        sample();
        chk("reset_req",   {15'd0, mem_req}, 16'd0);
        chk("reset_stall", {15'd0, stall},   16'd0);
        chk("reset_rmd",   readMemData,      16'd0);
        chk("reset_err",   {15'd0, err},     16'd0);
        step();
        rst = 1'b0;

        // Bubbles and no-op instructions never issue, stall or flag.
        for (int i = 0; i < 5; i++) begin
            step();
            valid    = vecs[i].v;
            memRead  = vecs[i].rd;
            memWrite = vecs[i].wr;
            addr     = vecs[i].a;
            wrData   = vecs[i].d;
            sample();
            chk($sformatf("vec%0d_req", i),   {15'd0, mem_req}, {15'd0, vecs[i].e_req});
            chk($sformatf("vec%0d_stall", i), {15'd0, stall},   {15'd0, vecs[i].e_stall});
            chk($sformatf("vec%0d_wr", i),    {15'd0, mem_wr},  16'd0);
            chk($sformatf("vec%0d_addr", i),  mem_addr,  vecs[i].a);
            chk($sformatf("vec%0d_wdata", i), mem_wdata, vecs[i].d);
        end
        step();
        drive_idle();
        sample();
        chk("vec_err_after", {15'd0, err}, 16'd0);

        do_access(1'b0, 16'h0010, 16'h0000, 3, 16'hBEEF, 1'b0, "load1");
        step();
        drive_idle();
        do_access(1'b1, 16'h0020, 16'h1234, 1, 16'hAAAA, 1'b0, "store1");
        step();
        drive_idle();

        req_before = req_cnt;
        do_access(1'b0, 16'h0002, 16'h0000, 2, 16'h1111, 1'b0, "b2b_a");
        do_access(1'b0, 16'h0004, 16'h0000, 2, 16'h2222, 1'b0, "b2b_b");
        step();
        drive_idle();
        sample();
        chk("b2b_req_pulses", 16'(req_cnt - req_before), 16'd2);

        do_access(1'b0, 16'h0008, 16'h0000, 0, 16'h0000, 1'b1, "timeout");
        step();
        drive_idle();
        sample();
        chk("timeout_idle_stall", {15'd0, stall}, 16'd0);
        chk("timeout_err_hold",   {15'd0, err},   16'd1);

        // Reset during the second WAIT cycle; the late mem_done must be ignored.
        step();
        valid   = 1'b1;
        memRead = 1'b1;
        addr    = 16'h0030;
        sample();
        chk("rstmid_issue", {15'd0, mem_req}, 16'd1);
        step();
        step();
        rst = 1'b1;
        #1;
        chk("rstmid_stall", {15'd0, stall},   16'd0);
        chk("rstmid_req",   {15'd0, mem_req}, 16'd0);
        chk("rstmid_err",   {15'd0, err},     16'd0);
        rmd_model = 16'h0;
        sb.delete();
        drive_idle();
        step();
        rst = 1'b0;
        step();
        mem_done  = 1'b1;
        mem_rdata = 16'h5555;
        sample();
        chk("rstmid_late_stall", {15'd0, stall}, 16'd0);
        step();
        mem_done = 1'b0;
        sample();
        chk("rstmid_late_rmd", readMemData, 16'd0);
        chk("rstmid_late_err", {15'd0, err}, 16'd0);

        // Unaligned load: no request, error on the following edge.
        step();
        valid   = 1'b1;
        memRead = 1'b1;
        addr    = 16'h0011;
        sample();
        chk("unal_req",   {15'd0, mem_req}, 16'd0);
        chk("unal_stall", {15'd0, stall},   16'd0);
        chk("unal_err0",  {15'd0, err},     16'd0);
        step();
        drive_idle();
        sample();
        chk("unal_err1", {15'd0, err}, 16'd1);
        step();
        sample();
        chk("unal_err_sticky", {15'd0, err}, 16'd1);
        chk("unal_rmd",        readMemData,  16'd0);

        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        sample();
        chk("illeg_err_cleared", {15'd0, err}, 16'd0);

        // Illegal load+store: no request, error flagged and held.
        step();
        valid    = 1'b1;
        memRead  = 1'b1;
        memWrite = 1'b1;
        addr     = 16'h0040;
        sample();
        chk("illeg_req",   {15'd0, mem_req}, 16'd0);
        chk("illeg_stall", {15'd0, stall},   16'd0);
        step();
        drive_idle();
        sample();
        chk("illeg_err1", {15'd0, err}, 16'd1);
        step();
        step();
        sample();
        chk("illeg_err_sticky", {15'd0, err}, 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
